// File: rtl/video_pkg.sv
// Shared definitions for the video frame capture block: FSM states, default
// geometry and the saturating counter helper.
package video_pkg;

    localparam int unsigned DefImgWidth  = 1280;
    localparam int unsigned DefImgHeight = 720;
    localparam int unsigned CntWidth     = 12;

    typedef enum logic [1:0] {
        StSync,
        StIdle,
        StCapture
    } state_e;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

endpackage

// File: rtl/video_pixel_packer.sv
// Collects PACK pixels into one output word, first pixel in the LSB lane.
// A flush emits a partial word with the unused upper lanes zeroed.
module video_pixel_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4
) (
    input  logic                       video_clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      pix,
    input  logic                       flush,
    output logic                       word_valid,
    output logic [PACK*DATA_WIDTH-1:0] word_data
);

    localparam int unsigned CntW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CntW-1:0] LastLane = CntW'(PACK - 1);

    logic [PACK-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic                            valid_q, valid_d;
    logic [PACK*DATA_WIDTH-1:0]      word_q, word_d;

    // Lanes are zeroed whenever a word leaves, so a flushed word is already padded.
    always_comb begin
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        word_d  = word_q;
        if (clear) begin
            lanes_d = '0;
            cnt_d   = '0;
        end else if (push) begin
            lanes_d[cnt_q] = pix;
            if (cnt_q == LastLane) begin
                valid_d = 1'b1;
                word_d  = lanes_d;
                lanes_d = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (flush && cnt_q != '0) begin
            valid_d = 1'b1;
            word_d  = lanes_q;
            lanes_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign word_valid = valid_q;
    assign word_data  = word_q;

endmodule

// File: rtl/video_frame_capture.sv
// Captures one video frame into packed memory words and measures its geometry.
// A frame is the video_vs high window; lines are video_de high bursts.
module video_frame_capture
    import video_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = DefImgWidth,
    parameter int unsigned IMG_HEIGHT = DefImgHeight,
    parameter int unsigned PACK       = 4,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                       video_clk,
    input  logic                       rst_n,
    input  logic                       video_vs,
    input  logic                       video_de,
    input  logic [DATA_WIDTH-1:0]      video_data,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [PACK*DATA_WIDTH-1:0] wr_data,
    output logic                       frame_start,
    output logic                       frame_done,
    output logic                       frame_ok,
    output logic [CntWidth-1:0]        meas_width,
    output logic [CntWidth-1:0]        meas_height,
    output logic                       busy
);

    localparam logic [CntWidth-1:0] ExpWidth  = CntWidth'(IMG_WIDTH);
    localparam logic [CntWidth-1:0] ExpHeight = CntWidth'(IMG_HEIGHT);

    state_e                state_q, state_d;
    logic                  vs_d, de_d;
    logic [CntWidth-1:0]   x_q, x_d, y_q, y_d, last_w_q, last_w_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  start_q, start_d, done_q, done_d, ok_q, ok_d, busy_q, busy_d;
    logic [CntWidth-1:0]   mw_q, mw_d, mh_q, mh_d;
    logic                  frame_clear;

    logic in_cap, vs_rise, vs_fall, pix_accept, pix_drop, line_close;

    assign in_cap     = (state_q == StCapture);
    assign vs_rise    = video_vs & ~vs_d;
    assign vs_fall    = ~video_vs & vs_d;
    assign pix_accept = in_cap & video_de & ~vs_fall;
    assign pix_drop   = in_cap & video_de & vs_fall;
    // de_d only tracks accepted pixels, so an open line exists only inside a frame.
    assign line_close = in_cap & de_d & (~video_de | vs_fall);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        err_d       = err_q;
        last_w_d    = last_w_q;
        addr_d      = wr_en ? addr_q + ADDR_WIDTH'(1) : addr_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        ok_d        = ok_q;
        mw_d        = mw_q;
        mh_d        = mh_q;
        frame_clear = 1'b0;
        unique case (state_q)
            StSync: begin
                if (!video_vs) state_d = StIdle;
            end
            StIdle: begin
                if (vs_rise) begin
                    state_d     = StCapture;
                    start_d     = 1'b1;
                    frame_clear = 1'b1;
                    x_d         = '0;
                    y_d         = '0;
                    err_d       = 1'b0;
                    last_w_d    = '0;
                    addr_d      = '0;
                end
            end
            StCapture: begin
                if (pix_accept) x_d = sat_inc(x_q);
                if (line_close) begin
                    x_d      = '0;
                    y_d      = sat_inc(y_q);
                    last_w_d = x_q;
                    if (x_q != ExpWidth) err_d = 1'b1;
                end
                if (pix_drop) err_d = 1'b1;
                // Results include the line closed on this same cycle.
                if (vs_fall) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    mw_d    = last_w_d;
                    mh_d    = y_d;
                    ok_d    = !err_d && (y_d == ExpHeight);
                end
            end
            default: state_d = StSync;
        endcase
        busy_d = (state_d == StCapture);
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StSync;
            vs_d     <= 1'b0;
            de_d     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            last_w_q <= '0;
            addr_q   <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            mw_q     <= '0;
            mh_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_d     <= video_vs;
            de_d     <= pix_accept;
            x_q      <= x_d;
            y_q      <= y_d;
            err_q    <= err_d;
            last_w_q <= last_w_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            mw_q     <= mw_d;
            mh_q     <= mh_d;
            busy_q   <= busy_d;
        end
    end

    video_pixel_packer #(
        .DATA_WIDTH(DATA_WIDTH),
        .PACK      (PACK)
    ) u_packer (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .clear     (frame_clear),
        .push      (pix_accept),
        .pix       (video_data),
        .flush     (line_close),
        .word_valid(wr_en),
        .word_data (wr_data)
    );

    assign wr_addr     = addr_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign frame_ok    = ok_q;
    assign meas_width  = mw_q;
    assign meas_height = mh_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// Directed bench for video_frame_capture with a write scoreboard fed by a
// reference packing model.
module tb_video_frame_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  data = '0;
    logic        wr_en;
    logic [19:0] wr_addr;
    logic [31:0] wr_data;
    logic        frame_start, frame_done, frame_ok, busy;
    logic [11:0] meas_width, meas_height;

    int total = 0, bad = 0;
    int wr_cnt = 0, start_cnt = 0, done_cnt = 0;
    int exp_addr = 0;
    logic [51:0] sb[$];

    always #5 clk = ~clk;

    video_frame_capture #(
        .DATA_WIDTH(8),
        .IMG_WIDTH (8),
        .IMG_HEIGHT(4),
        .PACK      (4),
        .ADDR_WIDTH(20)
    ) dut (
        .video_clk  (clk),
        .rst_n      (rst_n),
        .video_vs   (vs),
        .video_de   (de),
        .video_data (data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .meas_width (meas_width),
        .meas_height(meas_height),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: counts pulses and pops the scoreboard on every write.
    always @(negedge clk) begin
        logic [51:0] e;
        if (rst_n) begin
            if (frame_start) start_cnt++;
            if (frame_done) done_cnt++;
            if (wr_en) begin
                wr_cnt++;
                total++;
                assert (sb.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_write got=%0h:%0h exp=none", wr_addr, wr_data);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e[51:32]));
                    check("wr_data", 64'(wr_data), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic frame_begin();
        int s;
        s = start_cnt;
        @(posedge clk);
        #1 vs = 1'b1;
        exp_addr = 0;
        repeat (3) @(negedge clk);
        check("frame_start", 64'(start_cnt), 64'(s + 1));
        check("busy_capture", 64'(busy), 64'd1);
    endtask

    task automatic send_line(input int first, input int n, input bit push);
        logic [31:0] acc;
        int k;
        acc = '0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 de = 1'b1;
            data = 8'(first + i);
            if (push) begin
                acc = acc | (32'(data) << (8 * k));
                k++;
                if (k == 4) begin
                    sb.push_back({20'(exp_addr), acc});
                    exp_addr++;
                    acc = '0;
                    k = 0;
                end
            end
        end
        @(posedge clk);
        #1 de = 1'b0;
        data = '0;
        if (push && k != 0) begin
            sb.push_back({20'(exp_addr), acc});
            exp_addr++;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic frame_end(input bit exp_ok, input int exp_w, input int exp_h);
        int d;
        d = done_cnt;
        @(posedge clk);
        #1 vs = 1'b0;
        for (int i = 0; i < 10 && done_cnt == d; i++) @(negedge clk);
        check("frame_done", 64'(done_cnt), 64'(d + 1));
        check("frame_ok", 64'(frame_ok), 64'(exp_ok));
        check("meas_width", 64'(meas_width), 64'(exp_w));
        check("meas_height", 64'(meas_height), 64'(exp_h));
        check("busy_after", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int w, s, d;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_ok", 64'(frame_ok), 64'd0);
        check("rst_meas_w", 64'(meas_width), 64'd0);
        check("rst_meas_h", 64'(meas_height), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal 4x8 frame, data 0x00..0x1F
        w = wr_cnt;
        frame_begin();
        for (int l = 0; l < 4; l++) send_line(8 * l, 8, 1'b1);
        frame_end(1'b1, 8, 4);
        check("a_writes", 64'(wr_cnt - w), 64'd8);

        // Short line 1 (6 pixels) -> padded word, bad frame
        w = wr_cnt;
        frame_begin();
        send_line(0, 8, 1'b1);
        send_line(8, 6, 1'b1);
        send_line(16, 8, 1'b1);
        send_line(24, 8, 1'b1);
        frame_end(1'b0, 8, 4);
        check("b_writes", 64'(wr_cnt - w), 64'd8);

        // Five lines -> height 5, bad frame
        w = wr_cnt;
        frame_begin();
        for (int l = 0; l < 5; l++) send_line(8 * l, 8, 1'b1);
        frame_end(1'b0, 8, 5);
        check("c_writes", 64'(wr_cnt - w), 64'd10);

        // Back-to-back frames; address must restart at 0 each time
        s = start_cnt;
        d = done_cnt;
        for (int f = 0; f < 2; f++) begin
            frame_begin();
            for (int l = 0; l < 4; l++) send_line(100 + 8 * l, 8, 1'b1);
            frame_end(1'b1, 8, 4);
        end
        check("btb_starts", 64'(start_cnt - s), 64'd2);
        check("btb_dones", 64'(done_cnt - d), 64'd2);

        // Reset released mid-frame: that frame is discarded
        @(posedge clk);
        #1 rst_n = 1'b0;
        vs = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        s = start_cnt;
        d = done_cnt;
        w = wr_cnt;
        send_line(0, 8, 1'b0);
        send_line(8, 8, 1'b0);
        check("discard_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 vs = 1'b0;
        repeat (3) @(posedge clk);
        check("discard_start", 64'(start_cnt), 64'(s));
        check("discard_done", 64'(done_cnt), 64'(d));
        check("discard_writes", 64'(wr_cnt), 64'(w));
        frame_begin();
        for (int l = 0; l < 4; l++) send_line(50 + 8 * l, 8, 1'b1);
        frame_end(1'b1, 8, 4);

        // Reset asserted mid-line while a write is on the bus
        frame_begin();
        send_line(0, 8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 de = 1'b1;
            data = 8'(i);
        end
        @(posedge clk);
        #1;
        check("pre_rst_wr_en", 64'(wr_en), 64'd1);
        check("pre_rst_wr_addr", 64'(wr_addr), 64'd2);
        check("pre_rst_busy", 64'(busy), 64'd1);
        d = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        de = 1'b0;
        vs = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check("mid_rst_no_done", 64'(done_cnt), 64'(d));
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
